// File: rtl/shl_inv_pkg.sv
// Shared encodings for the shift-left invertibility witness search.
package shl_inv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] PRED_SLE = 2'd0;
  localparam logic [1:0] PRED_SLT = 2'd1;
  localparam logic [1:0] PRED_ULE = 2'd2;
  localparam logic [1:0] PRED_ULT = 2'd3;

  localparam logic POS_X_SHL_S = 1'b0;
  localparam logic POS_S_SHL_X = 1'b1;

endpackage

// File: rtl/shl_pred_eval.sv
// Combinational test of one candidate: (cand << s) or (s << cand) against t.
module shl_pred_eval
  import shl_inv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  input  logic [W-1:0] cand,
  input  logic [1:0]   pred,
  input  logic         pos,
  output logic         sat
);

  logic [W-1:0]        base;
  logic [W-1:0]        amt;
  logic [W-1:0]        lhs;
  logic signed [W-1:0] lhs_sg;
  logic signed [W-1:0] t_sg;

  assign base   = (pos == POS_S_SHL_X) ? s : cand;
  assign amt    = (pos == POS_S_SHL_X) ? cand : s;
  // A logical shift of a W-bit vector by >= W already yields zero, matching bvshl.
  assign lhs    = base << amt;
  assign lhs_sg = lhs;
  assign t_sg   = t;

  always_comb begin
    sat = 1'b0;
    case (pred)
      PRED_SLE: sat = (lhs_sg <= t_sg);
      PRED_SLT: sat = (lhs_sg <  t_sg);
      PRED_ULE: sat = (lhs <= t);
      PRED_ULT: sat = (lhs <  t);
      default:  sat = 1'b0;
    endcase
  end

endmodule

// File: rtl/shl_inv_search.sv
// Sequential search for the minimal x with (x << s) or (s << x) satisfying pred t.
module shl_inv_search
  import shl_inv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  input  logic [1:0]   pred,
  input  logic         pos,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x,
  output logic         found
);

  state_t       st;
  logic [W-1:0] s_r;
  logic [W-1:0] t_r;
  logic [1:0]   pred_r;
  logic         pos_r;
  logic [W-1:0] cand;
  logic         last;
  logic         sat;

  // Explicit last-candidate flag keeps the W-bit counter from wrapping unnoticed.
  assign last = &cand;

  shl_pred_eval #(.W(W)) u_eval (
    .s    (s_r),
    .t    (t_r),
    .cand (cand),
    .pred (pred_r),
    .pos  (pos_r),
    .sat  (sat)
  );

  // Operand capture: data only, no reset.
  always_ff @(posedge clk) begin
    if (st == IDLE && in_valid) begin
      s_r    <= s;
      t_r    <= t;
      pred_r <= pred;
      pos_r  <= pos;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      cand      <= '0;
      x         <= '0;
      found     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            cand     <= '0;
            st       <= SEARCH;
            in_ready <= 1'b0;
          end
        end
        SEARCH: begin
          if (abort) begin
            st       <= IDLE;
            in_ready <= 1'b1;
          end else if (sat) begin
            x         <= cand;
            found     <= 1'b1;
            st        <= DONE;
            out_valid <= 1'b1;
          end else if (last) begin
            x         <= '0;
            found     <= 1'b0;
            st        <= DONE;
            out_valid <= 1'b1;
          end else begin
            cand <= cand + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          st        <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shl_inv_search.sv
// Self-checking bench for shl_inv_search with directed cases and a brute-force model.
module tb_shl_inv_search;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] s = '0;
  logic [W-1:0] t = '0;
  logic [1:0]   pred = 2'd0;
  logic         pos = 1'b0;
  logic         abort = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] x;
  logic         found;

  int checks = 0;
  int errors = 0;

  shl_inv_search #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .t         (t),
    .pred      (pred),
    .pos       (pos),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .found     (found)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= N / 2) ? v - N : v;
  endfunction

  // Brute force over every candidate in increasing order.
  function automatic void model(input int ss, tt, pp, po,
                                output int ex, output int ef, output int el);
    ex = 0; ef = 0; el = N + 1;
    for (int k = 0; k < N; k++) begin
      int a, amt, lhs;
      bit ok;
      a   = po ? ss : k;
      amt = po ? k : ss;
      lhs = (amt >= W) ? 0 : ((a << amt) % N);
      case (pp)
        0: ok = to_signed(lhs) <= to_signed(tt);
        1: ok = to_signed(lhs) <  to_signed(tt);
        2: ok = lhs <= tt;
        default: ok = lhs < tt;
      endcase
      if (ok) begin
        ex = k; ef = 1; el = k + 2;
        break;
      end
    end
  endfunction

  // Called #1 after a rising edge with in_ready high; that cycle is cycle 0.
  task automatic run_req(input string tag, input int ss, tt, pp, po,
                         input int ex, ef, el, input bit ack);
    int  cyc;
    bit  seen;
    s = W'(ss); t = W'(tt); pred = 2'(pp); pos = 1'(po);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1; seen = 0;
    while (!seen && cyc <= 3 * N) begin
      if (out_valid) seen = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, "_latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, el);
    chk({tag, "_x"}, 32'(x), ex);
    chk({tag, "_found"}, 32'(found), ef);
    if (ack) begin
      s = ~s; t = ~t; abort = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      abort = 1'b0;
      chk({tag, "_hold_x"}, 32'(x), ex);
      chk({tag, "_hold_valid"}, 32'({out_valid, in_ready}), 2);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_to_idle"}, 32'({out_valid, in_ready}), 1);
    end
  endtask

  initial begin
    int ex, ef, el, ss, tt, pp, po, early;

    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk("reset", 32'({in_ready, out_valid, found, x}), 32'h80 >> (7 - W - 2));

    run_req("zero",   0, 0,   0, 0, 0, 1, 2,  1);
    run_req("s1_t8",  1, 8,   0, 1, 3, 1, 5,  1);
    run_req("sh_ge_w", 4, 15, 0, 0, 0, 0, 17, 1);
    run_req("ult_t0", 5, 0,   3, 0, 0, 0, 17, 1);
    run_req("slt_min", 3, 8,  1, 1, 0, 0, 17, 1);

    // Abort asserted in cycle 3 of a search that would never find a witness.
    s = 4'd4; t = 4'd15; pred = 2'd0; pos = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    early = 0;
    repeat (2) begin
      if (out_valid) early++;
      @(posedge clk); #1;
    end
    if (out_valid) early++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_no_valid", 32'(early), 0);
    chk("abort_idle", 32'({out_valid, in_ready}), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", 32'({out_valid, in_ready}), 1);
    run_req("after_abort", 1, 8, 0, 1, 3, 1, 5, 1);

    // Reset in the middle of a search, with x still holding the previous witness.
    s = 4'd4; t = 4'd15; pred = 2'd0; pos = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rst_search", 32'({in_ready, out_valid, found, x}), 32'h40);

    // Reset while DONE is stalled by out_ready=0.
    run_req("pre_rst_done", 1, 8, 0, 1, 3, 1, 5, 0);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rst_done", 32'({in_ready, out_valid, found, x}), 32'h40);

    for (int i = 0; i < 30; i++) begin
      ss = $urandom_range(0, N - 1);
      tt = $urandom_range(0, N - 1);
      pp = $urandom_range(0, 3);
      po = $urandom_range(0, 1);
      model(ss, tt, pp, po, ex, ef, el);
      run_req($sformatf("rand%0d", i), ss, tt, pp, po, ex, ef, el, (i % 2) == 0);
      if (out_valid) begin
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
